led_share_arbiter: RTL and testbench

- Shares the board LED bank between NREQ requesters, e.g. the blinky counter and the attosoc LED port, on the PS8-derived fabric clock.
- Time-slices ownership with round-robin arbitration and a minimum dwell per owner.
- Inserts a one-cycle blank between owners.
- Drives the registered LED outputs directly.

---
 rtl/led_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 33 +++
 rtl/led_share_arbiter.sv | 110 +++++++++++
 tb/tb_led_share_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED bank arbiter: FSM state encodings and a
// ceil-log2 helper that never returns less than one bit.
package led_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  function automatic int clog2_min1(input int value);
    int width;
    width = $clog2(value);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit found searching
// upward from ptr+1, wrapping modulo NREQ with an explicit compare.
module rr_pick
  import led_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  int w_pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_pos = 0;
    for (int off = 1; off <= NREQ; off++) begin
      w_pos = int'(ptr) + off;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!valid && (i == w_pos) && req[i]) begin
          valid = 1'b1;
          idx   = PW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/led_share_arbiter.sv
// Time-slices the LED bank between requesters: round-robin owner selection,
// minimum dwell before preemption, and a one-cycle idle blank between owners.
module led_share_arbiter
  import led_arb_pkg::*;
#(
  parameter int               NREQ         = 2,
  parameter int               LED_W        = 4,
  parameter int               DWELL_CYCLES = 1048576,
  parameter logic [LED_W-1:0] IDLE_PATTERN = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LED_W-1:0] pattern,
  output logic [NREQ-1:0]       grant,
  output logic [LED_W-1:0]      led,
  output logic                  busy
);

  localparam int PW = clog2_min1(NREQ);
  localparam int DW = clog2_min1(DWELL_CYCLES);

  arb_state_t        r_state, w_nxt_state;
  logic [NREQ-1:0]   r_grant, w_nxt_grant;
  logic [LED_W-1:0]  r_led, w_nxt_led;
  logic              r_busy;
  logic [PW-1:0]     r_ptr, w_nxt_ptr;
  logic [DW-1:0]     r_dwell, w_nxt_dwell;

  logic              w_pick_vld;
  logic [PW-1:0]     w_pick_idx;
  logic [NREQ-1:0]   w_pick_oh;
  logic [LED_W-1:0]  w_own_pat;
  logic              w_own_req;
  logic              w_other_req;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_pick_vld),
    .idx   (w_pick_idx)
  );

  assign w_pick_oh   = NREQ'(1) << w_pick_idx;
  assign w_own_req   = |(req & r_grant);
  assign w_other_req = |(req & ~r_grant);

  // r_grant is one-hot while owning, so it selects the owner's pattern slice.
  always_comb begin
    w_own_pat = IDLE_PATTERN;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) w_own_pat = pattern[i*LED_W +: LED_W];
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = '0;
    w_nxt_led   = IDLE_PATTERN;
    w_nxt_ptr   = r_ptr;
    w_nxt_dwell = r_dwell;
    case (r_state)
      ST_OWN: begin
        if (!w_own_req) begin
          w_nxt_state = w_other_req ? ST_GAP : ST_IDLE;
        end else if ((r_dwell == '0) && w_other_req) begin
          w_nxt_state = ST_GAP;
        end else begin
          w_nxt_grant = r_grant;
          w_nxt_led   = w_own_pat;
          if (r_dwell != '0) w_nxt_dwell = r_dwell - DW'(1);
        end
      end
      default: begin
        // IDLE and GAP share the pick; GAP falls back to IDLE when nobody asks.
        if (w_pick_vld) begin
          w_nxt_state = ST_OWN;
          w_nxt_grant = w_pick_oh;
          w_nxt_ptr   = w_pick_idx;
          w_nxt_dwell = DW'(DWELL_CYCLES - 1);
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_led   <= IDLE_PATTERN;
      r_busy  <= 1'b0;
      r_ptr   <= PW'(NREQ - 1);
      r_dwell <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_grant <= w_nxt_grant;
      r_led   <= w_nxt_led;
      r_busy  <= (w_nxt_state != ST_IDLE);
      r_ptr   <= w_nxt_ptr;
      r_dwell <= w_nxt_dwell;
    end
  end

  assign grant = r_grant;
  assign led   = r_led;
  assign busy  = r_busy;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboard bench: each directed vector pushes its expected post-edge
// grant/led/busy, and a monitor pops and compares after every clock edge.
module tb_led_share_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [7:0] pattern;
  logic [1:0] grant;
  logic [3:0] led;
  logic       busy;

  led_share_arbiter #(
    .NREQ(2), .LED_W(4), .DWELL_CYCLES(4), .IDLE_PATTERN(4'b0000)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .pattern(pattern),
    .grant(grant), .led(led), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [1:0] req;
    logic [3:0] p0;
    logic [3:0] p1;
    logic [1:0] g;
    logic [3:0] led;
    logic       busy;
  } vec_t;

  typedef struct packed {
    logic [1:0] g;
    logic [3:0] led;
    logic       busy;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, input logic [1:0] rq, input logic [3:0] p0,
                     input logic [3:0] p1, input logic [1:0] g, input logic [3:0] l,
                     input logic b);
    vec_t v;
    v = '{rst: rst, req: rq, p0: p0, p1: p1, g: g, led: l, busy: b};
    vecs.push_back(v);
  endtask

  // Monitor: compares DUT outputs 2ns after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (grant !== e.g) begin
          bad++;
          $display("FAIL grant vec=%0d got=%b want=%b", e.idx, grant, e.g);
        end
        total++;
        if (led !== e.led) begin
          bad++;
          $display("FAIL led vec=%0d got=%h want=%h", e.idx, led, e.led);
        end
        total++;
        if (busy !== e.busy) begin
          bad++;
          $display("FAIL busy vec=%0d got=%b want=%b", e.idx, busy, e.busy);
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   wait_cycles;
    reset   = 1'b1;
    req     = 2'b00;
    pattern = 8'h00;

    // Reset held with both requesting.
    add(1, 2'b11, 4'hA, 4'h3, 2'b00, 4'h0, 0);
    add(1, 2'b11, 4'hA, 4'h3, 2'b00, 4'h0, 0);
    add(1, 2'b11, 4'hA, 4'h3, 2'b00, 4'h0, 0);
    // Fairness: 0 wins first, 4-cycle ownership, blank, then 1, blank, then 0.
    add(0, 2'b11, 4'hA, 4'h3, 2'b01, 4'h0, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b01, 4'hA, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b01, 4'hA, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b01, 4'hA, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b00, 4'h0, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b10, 4'h0, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b10, 4'h3, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b10, 4'h3, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b10, 4'h3, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b00, 4'h0, 1);
    add(0, 2'b11, 4'hA, 4'h3, 2'b01, 4'h0, 1);
    // Early release by owner 0 with 1 waiting: blank then 1 owns.
    add(0, 2'b10, 4'hA, 4'h3, 2'b00, 4'h0, 1);
    add(0, 2'b10, 4'hA, 4'h3, 2'b10, 4'h0, 1);
    add(0, 2'b10, 4'hA, 4'h3, 2'b10, 4'h3, 1);
    // Release with nobody waiting goes straight to idle.
    add(0, 2'b00, 4'hA, 4'h3, 2'b00, 4'h0, 0);
    add(0, 2'b00, 4'hA, 4'h3, 2'b00, 4'h0, 0);
    // Single owner holds past dwell expiry with no blank.
    add(0, 2'b01, 4'hA, 4'h3, 2'b01, 4'h0, 1);
    for (int i = 0; i < 8; i++) add(0, 2'b01, 4'hA, 4'h3, 2'b01, 4'hA, 1);
    add(0, 2'b01, 4'h5, 4'h3, 2'b01, 4'h5, 1);
    // Requester 1 arrives after dwell expired: immediate preemption.
    add(0, 2'b11, 4'h5, 4'h3, 2'b00, 4'h0, 1);
    add(0, 2'b11, 4'h5, 4'h3, 2'b10, 4'h0, 1);
    add(0, 2'b11, 4'h5, 4'h3, 2'b10, 4'h3, 1);
    add(0, 2'b11, 4'h5, 4'h3, 2'b10, 4'h3, 1);
    add(0, 2'b11, 4'h5, 4'h3, 2'b10, 4'h3, 1);
    add(0, 2'b11, 4'h5, 4'h3, 2'b00, 4'h0, 1);
    add(0, 2'b11, 4'h5, 4'h3, 2'b01, 4'h0, 1);
    add(0, 2'b11, 4'h5, 4'h3, 2'b01, 4'h5, 1);
    // Mid-ownership reset, then only requester 1 asks.
    add(1, 2'b10, 4'h5, 4'h3, 2'b00, 4'h0, 0);
    add(0, 2'b10, 4'h5, 4'h3, 2'b10, 4'h0, 1);
    add(0, 2'b10, 4'h5, 4'h3, 2'b10, 4'h3, 1);
    add(0, 2'b00, 4'h5, 4'h3, 2'b00, 4'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset   = vecs[i].rst;
      req     = vecs[i].req;
      pattern = {vecs[i].p1, vecs[i].p0};
      e = '{g: vecs[i].g, led: vecs[i].led, busy: vecs[i].busy, idx: i};
      exp_q.push_back(e);
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
